// File: rtl/dffram_2r1w_arbiter.sv
// dffram_2r1w_arbiter: shares one 256x16 2R1W DFFRAM between one writer
// and NRD readers; round-robin read grants, throttled write priority.
module dffram_2r1w_arbiter #(
   parameter int NRD          = 4,
   parameter int WR_MAX_BURST = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_addr,
   input  logic [1:0]        wr_be,
   input  logic [15:0]       wr_data,
   input  logic [NRD-1:0]    rd_valid,
   output logic [NRD-1:0]    rd_ready,
   input  logic [NRD*8-1:0]  rd_addr,
   output logic [NRD-1:0]    rd_rvalid,
   output logic [NRD*16-1:0] rd_rdata,
   output logic [1:0]        ram_we0,
   output logic              ram_en0,
   output logic              ram_en1,
   output logic [7:0]        ram_a0,
   output logic [7:0]        ram_a1,
   output logic [15:0]       ram_di0,
   input  logic [15:0]       ram_do0,
   input  logic [15:0]       ram_do1
);

   localparam int PW  = (NRD > 1) ? $clog2(NRD) : 1;
   localparam int WBW = $clog2(WR_MAX_BURST + 1);

   logic [PW-1:0]  rr_q, rr_d;
   logic [WBW-1:0] wb_q, wb_d;
   logic [NRD-1:0] rv_q;
   logic [NRD-1:0] pt_q, pt_d;

   logic [7:0]     ra [NRD];
   logic [NRD-1:0] elig;
   logic           throttle;
   logic           wr_go;
   logic           have_a, have_b;
   logic [PW-1:0]  a_idx, b_idx, idx_w;
   logic           p0_rd, p1_v;
   logic [PW-1:0]  p1_idx, last_idx;

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         ra[i] = rd_addr[8*i +: 8];
      end
   end

   // A reader hitting the write address waits a cycle so it sees new data.
   always_comb begin
      throttle = (wb_q == WBW'(WR_MAX_BURST));
      wr_go    = wr_valid & ~throttle & ~RST;
      for (int i = 0; i < NRD; i++) begin
         elig[i] = rd_valid[i] & ~RST
                 & ~(wr_go & (ra[i] == wr_addr));
      end
      have_a = 1'b0;
      have_b = 1'b0;
      a_idx  = '0;
      b_idx  = '0;
      idx_w  = '0;
      for (int k = 0; k < NRD; k++) begin
         idx_w = PW'((int'(rr_q) + k) % NRD);
         if (elig[idx_w]) begin
            if (!have_a) begin
               have_a = 1'b1;
               a_idx  = idx_w;
            end else if (!have_b) begin
               have_b = 1'b1;
               b_idx  = idx_w;
            end
         end
      end
      p0_rd  = ~wr_go & have_a;
      p1_v   = wr_go ? have_a : have_b;
      p1_idx = wr_go ? a_idx : b_idx;
   end

   always_comb begin
      wr_ready = wr_go;
      for (int i = 0; i < NRD; i++) begin
         pt_d[i]     = p1_v && (p1_idx == PW'(i));
         rd_ready[i] = (p0_rd && (a_idx == PW'(i))) || pt_d[i];
      end
      ram_en0 = wr_go | p0_rd;
      ram_we0 = wr_go ? wr_be : 2'b00;
      ram_di0 = wr_go ? wr_data : 16'h0000;
      ram_a0  = wr_go ? wr_addr : (p0_rd ? ra[a_idx] : 8'h00);
      ram_en1 = p1_v;
      ram_a1  = p1_v ? ra[p1_idx] : 8'h00;
   end

   always_comb begin
      last_idx = p1_v ? p1_idx : a_idx;
      rr_d     = rr_q;
      if (have_a) begin
         rr_d = (last_idx == PW'(NRD - 1)) ? '0 : last_idx + PW'(1);
      end
      wb_d = (wr_go && (|rd_valid)) ? wb_q + WBW'(1) : '0;
   end

   // Port tag selects which RAM output answers each reader.
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_rdata[16*i +: 16] = rv_q[i]
                              ? (pt_q[i] ? ram_do1 : ram_do0)
                              : 16'h0000;
      end
   end

   assign rd_rvalid = rv_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_q <= '0;
         wb_q <= '0;
         rv_q <= '0;
         pt_q <= '0;
      end else begin
         rr_q <= rr_d;
         wb_q <= wb_d;
         rv_q <= rd_ready;
         pt_q <= pt_d;
      end
   end

endmodule

// File: tb/tb_dffram_2r1w_arbiter.sv
// tb_dffram_2r1w_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration and memory model.
module tb_dffram_2r1w_arbiter;

   localparam int NRD = 4;
   localparam int WRB = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              wr_valid;
   logic              wr_ready;
   logic [7:0]        wr_addr;
   logic [1:0]        wr_be;
   logic [15:0]       wr_data;
   logic [NRD-1:0]    rd_valid;
   logic [NRD-1:0]    rd_ready;
   logic [NRD*8-1:0]  rd_addr;
   logic [NRD-1:0]    rd_rvalid;
   logic [NRD*16-1:0] rd_rdata;
   logic [1:0]        ram_we0;
   logic              ram_en0;
   logic              ram_en1;
   logic [7:0]        ram_a0;
   logic [7:0]        ram_a1;
   logic [15:0]       ram_di0;
   logic [15:0]       ram_do0;
   logic [15:0]       ram_do1;

   logic [7:0]  ra [NRD];
   logic [15:0] ram [256];
   logic [15:0] ref_mem [256];

   int n_chk = 0;
   int n_fail = 0;

   dffram_2r1w_arbiter #(.NRD(NRD), .WR_MAX_BURST(WRB)) dut (
      .CLK(CLK), .RST(RST),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .ram_we0(ram_we0), .ram_en0(ram_en0), .ram_en1(ram_en1),
      .ram_a0(ram_a0), .ram_a1(ram_a1), .ram_di0(ram_di0),
      .ram_do0(ram_do0), .ram_do1(ram_do1)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      for (int i = 0; i < NRD; i++) rd_addr[8*i +: 8] = ra[i];
   end

   // Synchronous-read 2R1W RAM macro
   always @(posedge CLK) begin
      if (ram_en0) begin
         if (ram_we0[0]) ram[ram_a0][7:0]  <= ram_di0[7:0];
         if (ram_we0[1]) ram[ram_a0][15:8] <= ram_di0[15:8];
         ram_do0 <= ram[ram_a0];
      end
      if (ram_en1) ram_do1 <= ram[ram_a1];
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      wr_valid = 1'b0;
      rd_valid = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle();
      repeat (2) cyc();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      wr_valid = 1'b1; wr_addr = 8'hF0; wr_be = 2'b11; wr_data = 16'h1234;
      rd_valid = '1;
      for (int i = 0; i < NRD; i++) ra[i] = 8'(i);
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         n_chk++;
         if (wr_ready !== 1'b0 || rd_ready !== '0 || rd_rvalid !== '0 ||
             ram_en0 !== 1'b0 || ram_en1 !== 1'b0 || ram_we0 !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs c%0d: wr_ready=%b rd_ready=%b rvalid=%b en0=%b en1=%b we0=%b, required all 0",
                     c, wr_ready, rd_ready, rd_rvalid, ram_en0, ram_en1, ram_we0);
         end
         cyc();
      end
      RST = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (wr_ready !== 1'b1 || rd_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_first_grant: wr_ready=%b rd_ready=%b, required 1 0001",
                  wr_ready, rd_ready);
      end
      cyc();
      idle();
      @(negedge CLK);
      n_chk++;
      if (rd_rvalid !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset_first_rvalid: got %b, required 0001", rd_rvalid);
      end
      cyc();
   endtask

   task automatic test_write_read();
      do_reset();
      wr_valid = 1'b1; wr_addr = 8'h12; wr_be = 2'b11; wr_data = 16'hBEEF;
      @(negedge CLK);
      n_chk++;
      if (wr_ready !== 1'b1 || ram_we0 !== 2'b11 || ram_a0 !== 8'h12 ||
          ram_di0 !== 16'hBEEF || ram_en0 !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_pins: rdy=%b we0=%b a0=%h di0=%h en0=%b, required 1 11 12 beef 1",
                  wr_ready, ram_we0, ram_a0, ram_di0, ram_en0);
      end
      cyc();
      wr_valid = 1'b0;
      rd_valid = 4'b0100; ra[2] = 8'h12;
      @(negedge CLK);
      n_chk++;
      if (rd_ready !== 4'b0100 || ram_a0 !== 8'h12 || ram_we0 !== 2'b00) begin
         n_fail++;
         $display("FAIL rd_grant2: rd_ready=%b a0=%h we0=%b, required 0100 12 00",
                  rd_ready, ram_a0, ram_we0);
      end
      cyc();
      rd_valid = '0;
      @(negedge CLK);
      n_chk++;
      if (rd_rvalid !== 4'b0100 || rd_rdata[32 +: 16] !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL wr_then_rd: rvalid=%b data=%h, required 0100 beef",
                  rd_rvalid, rd_rdata[32 +: 16]);
      end
      cyc();
      @(negedge CLK);
      n_chk++;
      if (rd_rvalid !== 4'b0000) begin
         n_fail++;
         $display("FAIL rvalid_one_cycle: got %b, required 0000", rd_rvalid);
      end
      cyc();
   endtask

   task automatic test_byte_enable();
      do_reset();
      wr_valid = 1'b1; wr_addr = 8'h34; wr_be = 2'b11; wr_data = 16'hAAAA;
      cyc();
      wr_be = 2'b01; wr_data = 16'h5555;
      @(negedge CLK);
      n_chk++;
      if (wr_ready !== 1'b1 || ram_we0 !== 2'b01) begin
         n_fail++;
         $display("FAIL be_write: rdy=%b we0=%b, required 1 01", wr_ready, ram_we0);
      end
      cyc();
      wr_valid = 1'b0;
      rd_valid = 4'b0001; ra[0] = 8'h34;
      cyc();
      rd_valid = '0;
      @(negedge CLK);
      n_chk++;
      if (rd_rvalid !== 4'b0001 || rd_rdata[0 +: 16] !== 16'hAA55) begin
         n_fail++;
         $display("FAIL byte_enable: rvalid=%b data=%h, required 0001 aa55",
                  rd_rvalid, rd_rdata[0 +: 16]);
      end
      cyc();
   endtask

   task automatic test_hazard();
      do_reset();
      wr_valid = 1'b1; wr_addr = 8'h40; wr_be = 2'b11; wr_data = 16'h1111;
      rd_valid = 4'b0010; ra[1] = 8'h40;
      @(negedge CLK);
      n_chk++;
      if (wr_ready !== 1'b1 || rd_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL hazard_block: wr_ready=%b rd_ready=%b, required 1 0000",
                  wr_ready, rd_ready);
      end
      cyc();
      wr_valid = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (rd_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL hazard_next: rd_ready=%b, required 0010", rd_ready);
      end
      cyc();
      rd_valid = '0;
      @(negedge CLK);
      n_chk++;
      if (rd_rvalid !== 4'b0010 || rd_rdata[16 +: 16] !== 16'h1111) begin
         n_fail++;
         $display("FAIL hazard_data: rvalid=%b data=%h, required 0010 1111",
                  rd_rvalid, rd_rdata[16 +: 16]);
      end
      cyc();
   endtask

   task automatic test_round_robin();
      logic [NRD-1:0] exp_g, prev_g;
      logic [7:0]     base;
      do_reset();
      for (int i = 0; i < NRD; i++) begin
         wr_valid = 1'b1; wr_addr = 8'(8'h50 + i);
         wr_be = 2'b11; wr_data = 16'(16'hA000 + i);
         cyc();
      end
      do_reset();
      rd_valid = '1;
      for (int i = 0; i < NRD; i++) ra[i] = 8'(8'h50 + i);
      prev_g = '0;
      for (int c = 0; c < 4; c++) begin
         exp_g = (c % 2 == 0) ? 4'b0011 : 4'b1100;
         base  = (c % 2 == 0) ? 8'h50 : 8'h52;
         @(negedge CLK);
         n_chk++;
         if (rd_ready !== exp_g || ram_a0 !== base || ram_a1 !== base + 8'h01 ||
             ram_en0 !== 1'b1 || ram_en1 !== 1'b1 || ram_we0 !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_grant c%0d: rd_ready=%b a0=%h a1=%h, required %b %h %h",
                     c, rd_ready, ram_a0, ram_a1, exp_g, base, base + 8'h01);
         end
         if (c > 0) begin
            n_chk++;
            if (rd_rvalid !== prev_g) begin
               n_fail++;
               $display("FAIL rr_rvalid c%0d: got %b, required %b", c, rd_rvalid, prev_g);
            end
            for (int i = 0; i < NRD; i++) begin
               if (prev_g[i]) begin
                  n_chk++;
                  if (rd_rdata[16*i +: 16] !== 16'(16'hA000 + i)) begin
                     n_fail++;
                     $display("FAIL rr_data r%0d: got %h, required %h",
                              i, rd_rdata[16*i +: 16], 16'(16'hA000 + i));
                  end
               end
            end
         end
         prev_g = exp_g;
         cyc();
      end
      rd_valid = '0;
      @(negedge CLK);
      n_chk++;
      if (rd_rvalid !== 4'b1100 || rd_rdata[32 +: 16] !== 16'hA002 ||
          rd_rdata[48 +: 16] !== 16'hA003) begin
         n_fail++;
         $display("FAIL rr_last: rvalid=%b d2=%h d3=%h, required 1100 a002 a003",
                  rd_rvalid, rd_rdata[32 +: 16], rd_rdata[48 +: 16]);
      end
      cyc();
   endtask

   task automatic test_throttle();
      int gap;
      logic exp_w;
      do_reset();
      wr_valid = 1'b1; wr_addr = 8'h60; wr_be = 2'b11; wr_data = 16'h0F0F;
      rd_valid = 4'b1000; ra[3] = 8'h61;
      gap = 0;
      for (int c = 0; c < 15; c++) begin
         exp_w = (c % 5 != 4);
         @(negedge CLK);
         n_chk++;
         if (wr_ready !== exp_w || rd_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL throttle c%0d: wr_ready=%b rd_ready=%b, required %b 1000",
                     c, wr_ready, rd_ready, exp_w);
         end
         if (!exp_w) begin
            n_chk++;
            if (ram_en0 !== 1'b1 || ram_we0 !== 2'b00 || ram_a0 !== 8'h61) begin
               n_fail++;
               $display("FAIL throttle_read c%0d: en0=%b we0=%b a0=%h, required 1 00 61",
                        c, ram_en0, ram_we0, ram_a0);
            end
         end
         gap = rd_rvalid[3] ? 0 : gap + 1;
         n_chk++;
         if (gap >= 5 || (c > 0 && rd_rvalid[3] !== 1'b1)) begin
            n_fail++;
            $display("FAIL throttle_rvalid3 c%0d: rvalid=%b gap=%0d, required 1 each cycle",
                     c, rd_rvalid[3], gap);
         end
         cyc();
      end
      idle();
      cyc();
   endtask

   task automatic test_random();
      int             m_rr, m_wb, n, last, idx;
      logic           thr, wgo;
      logic [NRD-1:0] erdy, exp_rv;
      logic [15:0]    exp_dat [NRD];
      do_reset();
      for (int a = 0; a < 256; a++) ref_mem[a] = ram[a];
      m_rr = 0; m_wb = 0; exp_rv = '0;
      for (int i = 0; i < NRD; i++) exp_dat[i] = '0;
      for (int c = 0; c < 600; c++) begin
         if (!wr_valid && $urandom_range(0, 9) < 7) begin
            wr_valid = 1'b1;
            wr_addr  = 8'($urandom_range(0, 15));
            wr_be    = 2'($urandom_range(0, 3));
            wr_data  = 16'($urandom);
         end
         for (int i = 0; i < NRD; i++) begin
            if (!rd_valid[i] && $urandom_range(0, 9) < 5) begin
               rd_valid[i] = 1'b1;
               ra[i] = 8'($urandom_range(0, 15));
            end
         end
         @(negedge CLK);
         thr  = (m_wb == WRB);
         wgo  = wr_valid && !thr;
         erdy = '0; n = 0; last = 0;
         for (int k = 0; k < NRD; k++) begin
            idx = (m_rr + k) % NRD;
            if (rd_valid[idx] && !(wgo && ra[idx] == wr_addr) &&
                n < (wgo ? 1 : 2)) begin
               erdy[idx] = 1'b1;
               n++;
               last = idx;
            end
         end
         n_chk++;
         if (wr_ready !== wgo || rd_ready !== erdy) begin
            n_fail++;
            $display("FAIL rand_grant c%0d: wr_ready=%b rd_ready=%b, required %b %b",
                     c, wr_ready, rd_ready, wgo, erdy);
         end
         n_chk++;
         if (rd_rvalid !== exp_rv) begin
            n_fail++;
            $display("FAIL rand_rvalid c%0d: got %b, required %b", c, rd_rvalid, exp_rv);
         end
         for (int i = 0; i < NRD; i++) begin
            if (exp_rv[i]) begin
               n_chk++;
               if (rd_rdata[16*i +: 16] !== exp_dat[i]) begin
                  n_fail++;
                  $display("FAIL rand_data c%0d r%0d: got %h, required %h",
                           c, i, rd_rdata[16*i +: 16], exp_dat[i]);
               end
            end
         end
         for (int i = 0; i < NRD; i++) begin
            if (erdy[i]) exp_dat[i] = ref_mem[ra[i]];
         end
         exp_rv = erdy;
         if (wgo) begin
            if (wr_be[0]) ref_mem[wr_addr][7:0]  = wr_data[7:0];
            if (wr_be[1]) ref_mem[wr_addr][15:8] = wr_data[15:8];
         end
         if (n > 0) m_rr = (last + 1) % NRD;
         m_wb = (wgo && (|rd_valid)) ? m_wb + 1 : 0;
         cyc();
         if (wgo) wr_valid = 1'b0;
         for (int i = 0; i < NRD; i++) begin
            if (erdy[i]) rd_valid[i] = 1'b0;
         end
      end
      idle();
      cyc();
   endtask

   initial begin
      wr_valid = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_valid = '0;
      for (int i = 0; i < NRD; i++) ra[i] = '0;
      test_reset();
      test_write_read();
      test_byte_enable();
      test_hazard();
      test_round_robin();
      test_throttle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
